// File: rtl/osmlgd_pkg.sv
// Shared constants, FSM state type and parity helper for the one-step
// majority-logic LDPC decoder.
package osmlgd_pkg;

    localparam int N  = 256;
    localparam int M  = 128;
    localparam int CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYND = 2'd1,
        VOTE = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic parity_of(input logic [N-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/osmlgd_if.sv
// Work/free/valid handshake bundle between the hard-decision front end and
// the decoder.
interface osmlgd_if;
    import osmlgd_pkg::*;

    logic         work;
    logic [N-1:0] tx;
    logic         free;
    logic [N-1:0] deout;
    logic         valid;

    modport master (output work, output tx, input free, input deout, input valid);
    modport slave  (input work, input tx, output free, output deout, output valid);

endinterface

// File: rtl/osmlgd_vote.sv
// Per-bit majority vote: counts the failing checks touching this bit against
// the column weight and flips the received bit on a strict majority.
module osmlgd_vote
    import osmlgd_pkg::*;
(
    input  logic [M-1:0] i_col,
    input  logic [M-1:0] i_synd,
    input  logic         i_rx,
    output logic         o_bit
);

    logic [CW-1:0] w_unsat;
    logic [CW-1:0] w_wt;
    logic          w_flip;

    // Column weight and unsatisfied-check popcounts
    always_comb begin
        w_unsat = '0;
        w_wt    = '0;
        for (int i = 0; i < M; i++) begin
            w_wt    = w_wt + CW'(i_col[i]);
            w_unsat = w_unsat + CW'(i_col[i] & i_synd[i]);
        end
    end

    // 2*unsat > wt; a zero-weight column has unsat=0 and therefore never flips
    assign w_flip = ({w_unsat, 1'b0} > {1'b0, w_wt});
    assign o_bit  = i_rx ^ w_flip;

endmodule

// File: rtl/osmlgd_decoder.sv
// One-step majority-logic decoder top: holds the preloaded H matrix, computes
// the syndrome, runs the IDLE/SYND/VOTE/DONE sequence and registers outputs.
module osmlgd_decoder
    import osmlgd_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    osmlgd_if.slave  bus
);

    // Parity-check matrix, loaded externally by hierarchical name before use
    logic [N-1:0] Harray [0:M-1];

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_rx;
    logic [M-1:0] r_synd;
    logic [N-1:0] r_deout;
    logic         r_valid;

    logic [M-1:0] w_synd;
    logic [M-1:0] w_col [0:N-1];
    logic [N-1:0] w_corr;

    // Syndrome: parity of each H row masked by the captured word
    always_comb begin
        w_synd = '0;
        for (int i = 0; i < M; i++) begin
            w_synd[i] = parity_of(Harray[i] & r_rx);
        end
    end

    // Transpose H so each vote unit sees its own column
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_col[j] = '0;
            for (int i = 0; i < M; i++) begin
                w_col[j][i] = Harray[i][j];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_vote
        osmlgd_vote u_vote (
            .i_col  (w_col[j]),
            .i_synd (r_synd),
            .i_rx   (r_rx[j]),
            .o_bit  (w_corr[j])
        );
    end

    // Next-state logic; work is only honoured while idle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.work) begin
                    w_next = SYND;
                end else begin
                    w_next = IDLE;
                end
            end
            SYND:    w_next = VOTE;
            VOTE:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath registers: capture, syndrome, corrected word and valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx    <= '0;
            r_synd  <= '0;
            r_deout <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.work) begin
                        r_rx <= bus.tx;
                    end
                end
                SYND: r_synd <= w_synd;
                VOTE: begin
                    r_deout <= w_corr;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.free  = (r_state == IDLE);
    assign bus.deout = r_deout;
    assign bus.valid = r_valid;

endmodule

// File: tb/tb_osmlgd_decoder.sv
// Self-checking bench for osmlgd_decoder: directed vector table, reset/abort
// sequences and randomized H/word trials against a behavioural model.
module tb_osmlgd_decoder;
    import osmlgd_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    osmlgd_if bus ();

    osmlgd_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [N-1:0] h_proj  [0:M-1];
    logic [N-1:0] h_model [0:M-1];

    typedef struct {
        string        nm;
        logic         zero_h;
        logic         noise;
        logic [N-1:0] tx;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs [0:6];

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int b);
        logic [N-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    // Reference: syndromes from row parities, then per-bit strict majority vote
    function automatic logic [N-1:0] ref_decode(input logic [N-1:0] rx);
        logic [M-1:0] s;
        logic [N-1:0] out;
        int unsat, wt;
        for (int i = 0; i < M; i++) s[i] = ($countones(h_model[i] & rx) % 2) == 1;
        out = rx;
        for (int j = 0; j < N; j++) begin
            unsat = 0;
            wt    = 0;
            for (int i = 0; i < M; i++) begin
                if (h_model[i][j]) begin
                    wt++;
                    if (s[i]) unsat++;
                end
            end
            if (2 * unsat > wt) out[j] = ~out[j];
        end
        return out;
    endfunction

    task automatic load_h();
        for (int i = 0; i < M; i++) dut.Harray[i] = h_model[i];
    endtask

    task automatic wait_free(input string nm);
        int k;
        for (k = 0; k < 20; k++) begin
            if (bus.free) break;
            @(negedge clk);
        end
        if (k == 20) check({nm, "_free_timeout"}, 256'(bus.free), 256'(1));
    endtask

    // One decode: work for one cycle, then watch 8 cycles for exactly one valid
    task automatic run_decode(input logic [N-1:0] t, input logic [N-1:0] exp,
                              input logic noise, input string nm);
        int first_v, n_v;
        logic [N-1:0] got;
        wait_free(nm);
        bus.work = 1'b1;
        bus.tx   = t;
        @(posedge clk);
        @(negedge clk);
        if (noise) begin
            bus.work = 1'b1;
            bus.tx   = ~t;
        end else begin
            bus.work = 1'b0;
        end
        check({nm, "_busy"}, 256'(bus.free), 256'(0));
        first_v = 0;
        n_v     = 0;
        got     = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.valid) begin
                n_v++;
                if (first_v == 0) begin
                    first_v = k;
                    got     = bus.deout;
                end
            end
            if (k == 3) bus.work = 1'b0;
        end
        check({nm, "_npulse"}, 256'(n_v), 256'(1));
        check({nm, "_latency"}, 256'(first_v), 256'(3));
        check({nm, "_deout"}, got, exp);
    endtask

    initial begin
        logic [N-1:0] gt0, ones, a5, t, e;
        int u, v, cnt;

        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] gt0, ones, a5, t, e, base;
        int uu, vv, cnt;

        bus.work = 1'b0;
        bus.tx   = '0;

        // Project H: column (u,v) sits in rows u, 16+v, 32+((u+v) mod 16);
        // any two columns share at most one row, so single errors correct.
        for (int i = 0; i < M; i++) h_proj[i] = '0;
        for (int j = 0; j < N; j++) begin
            uu = j / 16;
            vv = j % 16;
            h_proj[uu][j]                    = 1'b1;
            h_proj[16 + vv][j]               = 1'b1;
            h_proj[32 + ((uu + vv) % 16)][j] = 1'b1;
        end
        // Codeword: XOR of {(u,v),(u,v+8),(u+8,v),(u+8,v+8)} quadruples
        gt0 = '0;
        for (int q = 0; q < 3; q++) begin
            uu = 2 * q + 1;
            vv = int'($urandom_range(0, 7));
            gt0[16 * uu + vv]           = ~gt0[16 * uu + vv];
            gt0[16 * uu + vv + 8]       = ~gt0[16 * uu + vv + 8];
            gt0[16 * (uu + 8) + vv]     = ~gt0[16 * (uu + 8) + vv];
            gt0[16 * (uu + 8) + vv + 8] = ~gt0[16 * (uu + 8) + vv + 8];
        end
        ones = '1;
        a5   = {32{8'hA5}};

        vecs[0] = '{"zero_word",   1'b0, 1'b0, '0,                      '0};
        vecs[1] = '{"codeword",    1'b0, 1'b0, gt0,                     gt0};
        vecs[2] = '{"bit17_noise", 1'b0, 1'b1, gt0 ^ onehot(17),        gt0};
        vecs[3] = '{"ones_err200", 1'b0, 1'b0, ones ^ onehot(200),      ones};
        vecs[4] = '{"err_bit0",    1'b0, 1'b0, gt0 ^ onehot(0),         gt0};
        vecs[5] = '{"err_bit255",  1'b0, 1'b0, gt0 ^ onehot(255),       gt0};
        vecs[6] = '{"zero_h_a5",   1'b1, 1'b0, a5,                      a5};

        for (int i = 0; i < M; i++) h_model[i] = h_proj[i];
        load_h();

        // Reset hold and idle release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_free", 256'(bus.free), 256'(1));
        check("rst_valid", 256'(bus.valid), 256'(0));
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_free", 256'(bus.free), 256'(1));
            check("idle_valid", 256'(bus.valid), 256'(0));
            check("idle_deout", bus.deout, '0);
        end

        // Directed vector table
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < M; i++) h_model[i] = vecs[k].zero_h ? '0 : h_proj[i];
            load_h();
            run_decode(vecs[k].tx, vecs[k].exp, vecs[k].noise, vecs[k].nm);
        end

        // Reset while in VOTE aborts the decode
        for (int i = 0; i < M; i++) h_model[i] = h_proj[i];
        load_h();
        run_decode(gt0 ^ onehot(40), gt0, 1'b0, "pre_abort");
        wait_free("abort");
        bus.work = 1'b1;
        bus.tx   = gt0 ^ onehot(5);
        @(posedge clk);
        @(negedge clk);
        bus.work = 1'b0;
        @(negedge clk);
        check("abort_busy", 256'(bus.free), 256'(0));
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", 256'(bus.valid), 256'(0));
        check("abort_deout", bus.deout, '0);
        check("abort_free", 256'(bus.free), 256'(1));
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.valid) cnt++;
        end
        check("abort_nopulse", 256'(cnt), 256'(0));
        run_decode(gt0 ^ onehot(5), gt0, 1'b0, "post_abort");

        // Random single errors on project-H codewords
        for (int k = 0; k < 6; k++) begin
            base = ($urandom_range(0, 1) == 1) ? (gt0 ^ ones) : gt0;
            e    = onehot(int'($urandom_range(0, N - 1)));
            run_decode(base ^ e, base, 1'b0, "rand_proj");
        end

        // Random H and random words against the reference model
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < M; i++) begin
                for (int w = 0; w < N / 32; w++) begin
                    h_model[i][w*32 +: 32] = $urandom & $urandom & $urandom;
                end
            end
            load_h();
            for (int w = 0; w < N / 32; w++) t[w*32 +: 32] = $urandom;
            run_decode(t, ref_decode(t), 1'b0, "rand_h");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
